spell_mem_spi: RTL and testbench
================================

Name: spell_mem_spi

Overview:
- Memory back-end for the spell core. It serves the core's byte-wide code and data memory requests from an external SPI SRAM (23LC512-class, mode 0, sequential byte mode).
- Sits directly downstream of the core's memory port and accepts the same select/addr/type/write/data_ready handshake.
- Code space and data space are two 256-byte windows of one SRAM.

Parameters:
- CLK_DIV, 2: SCK half-period in clock cycles; legal range 1..255.
- CS_HIGH_CYCLES, 2: minimum cycles spi_cs_n stays high between frames; legal range 1..255.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- select  input  1  core requests a transaction; held high until data_ready is seen
- addr  input  8  byte address within the selected space
- data_in  input  8  write data
- memory_type  input  2  `MemoryTypeData=0, `MemoryTypeCode=1, `MemoryTypeIO=2, `MemoryTypeNone=3
- write  input  1  1 = write, 0 = read
- data_out  output  8  read data; holds its value until the next completed read
- data_ready  output  1  one-cycle completion pulse
- busy  output  1  high from acceptance until return to IDLE
- spi_sck  output  1  SPI clock, idles low
- spi_cs_n  output  1  SPI chip select, idles high
- spi_mosi  output  1  SPI data out
- spi_miso  input  1  SPI data in

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, data_out=0, data_ready=0, busy=0.
  - Reset aborts any frame mid-operation on that same edge; no data_ready is issued.
- States: IDLE -> (SETUP -> SHIFT -> DONE -> GAP) or LOCAL -> RELEASE -> IDLE.
- Acceptance:
  - In IDLE with select=1, the inputs addr, data_in, memory_type and write are latched; busy goes high.
  - memory_type Data or Code -> SETUP.
  - memory_type IO or None -> LOCAL: data_ready=1 one cycle later, data_out=0 on reads, no SPI activity.
- Frame: 32 bits, MSB first.
  - Command: 0x03 for read, 0x02 for write.
  - 16-bit address {7'b0, memory_type==Data, addr}, so code maps to 0x0000-0x00FF and data to 0x0100-0x01FF.
  - 8 data bits: data_in on writes, don't-care (0) on reads.
- SETUP (1 cycle): spi_cs_n=0, spi_mosi=bit31.
- SHIFT: 64 half-phases of CLK_DIV cycles each.
  - SCK rises at the end of even phases; spi_miso is sampled on the rising edges of the last 8 bits.
  - SCK falls at the end of odd phases; spi_mosi advances on falling edges.
  - The final falling edge leaves spi_sck=0.
- DONE (1 cycle): spi_cs_n=1, data_ready=1, and data_out is updated on reads (valid in the same cycle as data_ready).
- Latency: data_ready is high exactly 2+64*CLK_DIV cycles after the accepting edge (130 cycles at CLK_DIV=2).
- GAP: hold spi_cs_n=1 for CS_HIGH_CYCLES cycles total, counting DONE.
- RELEASE: wait until select=0, then go to IDLE.
  - A request is never re-issued from a select level left over from the previous transaction.
  - The core drops select on the edge where it sees data_ready, so RELEASE normally lasts 1 cycle.
- Inputs are ignored while busy; changing them mid-frame has no effect.
- select dropping mid-frame: the frame completes and data_ready still pulses.
- CLK_DIV and CS_HIGH_CYCLES set to 0 are illegal; the block treats them as 1.

Optional Feature:
- Macro SPELL_MEM_CODE_CACHE_EN adds a one-entry code read buffer with fields valid, tag[7:0] and value[7:0].
- With the macro defined:
  - A code read whose addr equals tag while valid=1 goes through LOCAL: data_ready one cycle after acceptance, data_out=value, no SPI frame.
  - A code read miss fills the buffer at DONE.
  - A code write with addr==tag updates value at DONE.
  - Data-space accesses never touch the buffer.
  - Reset clears valid.
- Without the macro: every Data/Code access performs a full SPI frame.

Test Plan:
- Code read, CLK_DIV=2: select, memory_type=Code, addr=0x5A, SRAM[0x005A]=0xC3 -> MOSI carries 0x03,0x00,0x5A; data_ready pulses once at cycle 130; data_out=0xC3; spi_cs_n high for ≥2 cycles afterwards.
- Data write: memory_type=Data, addr=0x10, data_in=0x7E -> MOSI carries 0x02,0x01,0x10,0x7E; SRAM[0x0110]=0x7E; data_out unchanged.
- IO access: memory_type=IO, read -> data_ready one cycle after acceptance, data_out=0x00, spi_cs_n stays 1 throughout.
- Held select: select kept high for 20 cycles after data_ready -> no second frame starts; after select drops and rises again, exactly one new frame.
- Reset mid-frame: reset_n=0 at bit 12 -> next edge spi_cs_n=1, spi_sck=0, busy=0, no data_ready; a subsequent read of 0x005A returns 0xC3.
- With SPELL_MEM_CODE_CACHE_EN: read code 0x20 twice -> second read has data_ready one cycle after acceptance with no SPI activity; code write 0x20=0x99 then read -> 0x99.

Source files
------------

// File: rtl/spell_mem_spi.sv
// spell_mem_spi: serves byte-wide code/data requests from a mode-0 SPI SRAM (code at 0x0000, data at 0x0100).
// Define SPELL_MEM_CODE_CACHE_EN to add a one-entry code read buffer.
module spell_mem_spi #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       select,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic [1:0] memory_type,
  input  logic       write,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [1:0] MemTypeData = 2'd0;
  localparam logic [1:0] MemTypeCode = 2'd1;

  // Zero settings are illegal and behave as 1.
  localparam int unsigned DivEff  = (CLK_DIV == 0) ? 1 : CLK_DIV;
  localparam int unsigned CsEff   = (CS_HIGH_CYCLES == 0) ? 1 : CS_HIGH_CYCLES;
  localparam logic [7:0]  DivLast = 8'(DivEff - 1);
  localparam logic [7:0]  GapLast = 8'((CsEff >= 2) ? CsEff - 2 : 0);
  localparam bit          HasGap  = (CsEff >= 2);

  typedef enum logic [2:0] {
    StIdle, StSetup, StShift, StDone, StGap, StLocal, StRelease
  } state_e;

  state_e      state_q;
  logic        write_q;
  logic [31:0] frame_q;
  logic [7:0]  rxData_q;
  logic [7:0]  div_q;
  logic [5:0]  phase_q;
  logic [7:0]  gap_q;
  logic        sck_q, csN_q, mosi_q, ready_q, busy_q;
  logic [7:0]  dataOut_q;

  logic [31:0] frame_d;
  logic        isSpiType;
  logic        acceptHit;
  logic        localHit;
  logic [7:0]  localValue;

  assign frame_d   = {write ? 8'h02 : 8'h03, 7'b0, memory_type == MemTypeData,
                      addr, write ? data_in : 8'h00};
  assign isSpiType = (memory_type == MemTypeData) || (memory_type == MemTypeCode);

`ifdef SPELL_MEM_CODE_CACHE_EN
  logic       cacheValid_q;
  logic [7:0] cacheTag_q, cacheValue_q;
  logic [7:0] addr_q, data_q;
  logic [1:0] type_q;

  assign acceptHit  = !write && (memory_type == MemTypeCode) && cacheValid_q &&
                      (addr == cacheTag_q);
  assign localHit   = !write_q && (type_q == MemTypeCode) && cacheValid_q &&
                      (addr_q == cacheTag_q);
  assign localValue = cacheValue_q;

  // Code read misses fill the buffer; code writes to the buffered address refresh it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cacheValid_q <= 1'b0;
      cacheTag_q   <= 8'h00;
      cacheValue_q <= 8'h00;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      type_q       <= 2'd0;
    end else begin
      if (state_q == StIdle && select) begin
        addr_q <= addr;
        data_q <= data_in;
        type_q <= memory_type;
      end
      if (state_q == StDone && type_q == MemTypeCode) begin
        if (!write_q) begin
          cacheValid_q <= 1'b1;
          cacheTag_q   <= addr_q;
          cacheValue_q <= rxData_q;
        end else if (cacheValid_q && addr_q == cacheTag_q) begin
          cacheValue_q <= data_q;
        end
      end
    end
  end
`else
  assign acceptHit  = 1'b0;
  assign localHit   = 1'b0;
  assign localValue = 8'h00;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      frame_q   <= 32'h0;
      rxData_q  <= 8'h00;
      div_q     <= 8'h00;
      phase_q   <= 6'd0;
      gap_q     <= 8'h00;
      sck_q     <= 1'b0;
      csN_q     <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dataOut_q <= 8'h00;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (select) begin
            write_q <= write;
            frame_q <= frame_d;
            busy_q  <= 1'b1;
            state_q <= (isSpiType && !acceptHit) ? StSetup : StLocal;
          end
        end
        StSetup: begin
          csN_q   <= 1'b0;
          mosi_q  <= frame_q[31];
          frame_q <= {frame_q[30:0], 1'b0};
          div_q   <= 8'h00;
          phase_q <= 6'd0;
          state_q <= StShift;
        end
        // Even phases end with SCK rising (MISO sampled in the data byte), odd ones with SCK falling.
        StShift: begin
          if (div_q != DivLast) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q   <= 8'h00;
            phase_q <= phase_q + 6'd1;
            if (!phase_q[0]) begin
              sck_q <= 1'b1;
              if (phase_q >= 6'd48) rxData_q <= {rxData_q[6:0], spi_miso};
            end else begin
              sck_q <= 1'b0;
              if (phase_q == 6'd63) begin
                mosi_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                mosi_q  <= frame_q[31];
                frame_q <= {frame_q[30:0], 1'b0};
              end
            end
          end
        end
        StDone: begin
          csN_q   <= 1'b1;
          ready_q <= 1'b1;
          if (!write_q) dataOut_q <= rxData_q;
          gap_q   <= 8'h00;
          state_q <= HasGap ? StGap : StRelease;
        end
        StGap: begin
          if (gap_q == GapLast) state_q <= StRelease;
          else gap_q <= gap_q + 8'd1;
        end
        StLocal: begin
          ready_q <= 1'b1;
          if (!write_q) dataOut_q <= localHit ? localValue : 8'h00;
          state_q <= StRelease;
        end
        // A select level left over from the finished request must not start another one.
        StRelease: begin
          if (!select) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out   = dataOut_q;
  assign data_ready = ready_q;
  assign busy       = busy_q;
  assign spi_sck    = sck_q;
  assign spi_cs_n   = csN_q;
  assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_spell_mem_spi.sv
// Testbench for spell_mem_spi: behavioural SPI SRAM plus table-driven request vectors and hand sequences.
// Build with SPELL_MEM_CODE_CACHE_EN defined to also exercise the code read buffer.
module tb_spell_mem_spi;

  localparam int unsigned ClkDiv = 2;
  localparam int FrameLat = 2 + 64 * ClkDiv;
  localparam logic [1:0] TypeData = 2'd0;
  localparam logic [1:0] TypeCode = 2'd1;
  localparam logic [1:0] TypeIo   = 2'd2;
  localparam logic [1:0] TypeNone = 2'd3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       select = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [1:0] memory_type = 2'd0;
  logic       write = 1'b0;
  logic [7:0] data_out;
  logic       data_ready, busy, spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso = 1'b0;

  int passCount = 0;
  int totalCount = 0;

  always #5 clock = ~clock;

  spell_mem_spi #(.CLK_DIV(ClkDiv), .CS_HIGH_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .select(select), .addr(addr),
    .data_in(data_in), .memory_type(memory_type), .write(write),
    .data_out(data_out), .data_ready(data_ready), .busy(busy),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  // Behavioural 23LC512-style SRAM, sequential byte mode, mode 0.
  logic [7:0]  sram [0:511];
  int          bitCnt = 0;
  int          frameCount = 0;
  int          sckRises = 0;
  logic [31:0] rxShift = 32'h0;
  logic [31:0] lastFrame = 32'h0;
  logic [15:0] frameAddr = 16'h0;
  logic [7:0]  frameCmd = 8'h00;
  logic [7:0]  readByte;
  int          bitIdx;

  always @(negedge spi_cs_n) begin
    bitCnt = 0;
    frameCount++;
  end

  always @(posedge spi_sck) begin
    sckRises++;
    if (!spi_cs_n) begin
      rxShift = {rxShift[30:0], spi_mosi};
      bitCnt++;
      if (bitCnt == 24) begin
        frameCmd  = rxShift[23:16];
        frameAddr = rxShift[15:0];
      end
      if (bitCnt == 32) begin
        lastFrame = rxShift;
        if (frameCmd == 8'h02) sram[frameAddr[8:0]] = rxShift[7:0];
      end
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && frameCmd == 8'h03 && bitCnt >= 24 && bitCnt < 32) begin
      readByte = sram[frameAddr[8:0]];
      bitIdx   = 31 - bitCnt;
      spi_miso = readByte[bitIdx[2:0]];
    end
  end

  typedef struct {
    logic [1:0]  memType;
    logic        wr;
    logic [7:0]  a;
    logic [7:0]  d;
    logic        dropEarly;
    logic [7:0]  expOut;
    int          expLat;
    int          expFrames;
    logic [31:0] expFrame;
  } vec_t;

  function automatic vec_t mkVec(logic [1:0] t, logic wr, logic [7:0] a, logic [7:0] d,
                                 logic drop, logic [7:0] eo, int el, int ef, logic [31:0] fr);
    vec_t v;
    v.memType = t; v.wr = wr; v.a = a; v.d = d; v.dropEarly = drop;
    v.expOut = eo; v.expLat = el; v.expFrames = ef; v.expFrame = fr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Issues one request, scrambles the inputs mid-request, and waits (bounded) for data_ready.
  task automatic applyStimulus(input vec_t v, output int lat, output logic gotReady, output logic [7:0] dout);
    @(negedge clock);
    memory_type = v.memType; write = v.wr; addr = v.a; data_in = v.d; select = 1'b1;
    gotReady = 1'b0; lat = -1; dout = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (data_ready) begin
        gotReady = 1'b1; lat = i; dout = data_out; select = 1'b0;
        break;
      end
      if (i == 3) begin
        addr = ~addr; data_in = ~data_in; memory_type = memory_type ^ 2'b11; write = ~write;
        if (v.dropEarly) select = 1'b0;
      end
    end
    select = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    logic got;
    logic [7:0] dout;
    int f0, s0;
    f0 = frameCount; s0 = sckRises;
    applyStimulus(v, lat, got, dout);
    checkOutput({tag, " ready"}, 32'(got), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, " data_out"}, 32'(dout), 32'(v.expOut));
    checkOutput({tag, " frames"}, 32'(frameCount - f0), 32'(v.expFrames));
    checkOutput({tag, " sck_rises"}, 32'(sckRises - s0), 32'(32 * v.expFrames));
    if (v.expFrames != 0) checkOutput({tag, " mosi_frame"}, lastFrame, v.expFrame);
    @(negedge clock);
    checkOutput({tag, " ready_single"}, 32'(data_ready), 32'd0);
    checkOutput({tag, " cs_n_gap"}, 32'(spi_cs_n), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    vec_t vecs [10];
    int f0, pulses;
    logic got;

    for (int i = 0; i < 512; i++) sram[i] = 8'h00;
    sram[9'h05A] = 8'hC3;
    sram[9'h010] = 8'h3C;
    sram[9'h1FF] = 8'h18;
    sram[9'h100] = 8'hE7;
    sram[9'h020] = 8'h42;

    repeat (3) @(negedge clock);
    checkOutput("reset cs_n", 32'(spi_cs_n), 32'd1);
    checkOutput("reset sck", 32'(spi_sck), 32'd0);
    checkOutput("reset mosi", 32'(spi_mosi), 32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    checkOutput("reset ready", 32'(data_ready), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    vecs[0] = mkVec(TypeCode, 1'b0, 8'h5A, 8'h00, 1'b0, 8'hC3, FrameLat, 1, 32'h03005A00);
    vecs[1] = mkVec(TypeData, 1'b1, 8'h10, 8'h7E, 1'b0, 8'hC3, FrameLat, 1, 32'h0201107E);
    vecs[2] = mkVec(TypeData, 1'b0, 8'h10, 8'h00, 1'b0, 8'h7E, FrameLat, 1, 32'h03011000);
    vecs[3] = mkVec(TypeCode, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C, FrameLat, 1, 32'h03001000);
    vecs[4] = mkVec(TypeIo,   1'b0, 8'h33, 8'h00, 1'b0, 8'h00, 1,        0, 32'h0);
    vecs[5] = mkVec(TypeCode, 1'b1, 8'hFF, 8'h81, 1'b0, 8'h00, FrameLat, 1, 32'h0200FF81);
    vecs[6] = mkVec(TypeCode, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h81, FrameLat, 1, 32'h0300FF00);
    vecs[7] = mkVec(TypeNone, 1'b1, 8'h00, 8'h55, 1'b0, 8'h81, 1,        0, 32'h0);
    vecs[8] = mkVec(TypeData, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h18, FrameLat, 1, 32'h0301FF00);
    vecs[9] = mkVec(TypeData, 1'b0, 8'h00, 8'h00, 1'b0, 8'hE7, FrameLat, 1, 32'h03010000);

    for (int i = 0; i < 10; i++) runVector(vecs[i], $sformatf("vec%0d", i));
    checkOutput("sram data 0x110", 32'(sram[9'h110]), 32'h7E);
    checkOutput("sram code 0x0FF", 32'(sram[9'h0FF]), 32'h81);

    // Held select: no second frame until select drops and rises again.
    f0 = frameCount;
    @(negedge clock);
    memory_type = TypeData; write = 1'b0; addr = 8'h10; select = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (data_ready) begin got = 1'b1; break; end
    end
    checkOutput("held ready", 32'(got), 32'd1);
    checkOutput("held data_out", 32'(data_out), 32'h7E);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_ready) pulses++;
    end
    checkOutput("held extra_ready", 32'(pulses), 32'd0);
    checkOutput("held frames", 32'(frameCount - f0), 32'd1);
    checkOutput("held busy", 32'(busy), 32'd1);
    select = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("held released busy", 32'(busy), 32'd0);
    checkOutput("held released frames", 32'(frameCount - f0), 32'd1);
    runVector(mkVec(TypeData, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h18, FrameLat, 1, 32'h0301FF00), "held_rearm");

    // Reset in the middle of a frame.
    f0 = frameCount;
    @(negedge clock);
    memory_type = TypeData; write = 1'b0; addr = 8'h10; select = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (frameCount == f0 + 1 && bitCnt >= 12) begin got = 1'b1; break; end
    end
    checkOutput("abort reached bit12", 32'(got), 32'd1);
    reset_n = 1'b0; select = 1'b0;
    @(negedge clock);
    checkOutput("abort cs_n", 32'(spi_cs_n), 32'd1);
    checkOutput("abort sck", 32'(spi_sck), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort ready", 32'(data_ready), 32'd0);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (data_ready) pulses++;
    end
    checkOutput("abort no ready", 32'(pulses), 32'd0);
    checkOutput("abort no new frame", 32'(frameCount - f0), 32'd1);
    runVector(mkVec(TypeCode, 1'b0, 8'h5A, 8'h00, 1'b0, 8'hC3, FrameLat, 1, 32'h03005A00), "after_abort");

`ifdef SPELL_MEM_CODE_CACHE_EN
    runVector(mkVec(TypeCode, 1'b0, 8'h20, 8'h00, 1'b0, 8'h42, FrameLat, 1, 32'h03002000), "cache_miss");
    runVector(mkVec(TypeCode, 1'b0, 8'h20, 8'h00, 1'b0, 8'h42, 1,        0, 32'h0),        "cache_hit");
    runVector(mkVec(TypeCode, 1'b1, 8'h20, 8'h99, 1'b0, 8'h42, FrameLat, 1, 32'h02002099), "cache_write");
    runVector(mkVec(TypeCode, 1'b0, 8'h20, 8'h00, 1'b0, 8'h99, 1,        0, 32'h0),        "cache_reread");
    checkOutput("cache sram 0x020", 32'(sram[9'h020]), 32'h99);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
